// File: rtl/vmem_seq_pkg.sv
// rtl/vmem_seq_pkg.sv - shared types and op-field layout for the vector memory sequencer
//
// Purpose: FSM state enum, bit positions inside the 7-bit op word
// {memop, pattern[1:0], size[1:0], signed, we} and the address pattern codes.
// No ports.
package vmem_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  localparam int OP_W       = 7;
  localparam int OP_WE      = 0;
  localparam int OP_SIGNED  = 1;
  localparam int OP_SIZE_LO = 2;
  localparam int OP_SIZE_HI = 3;
  localparam int OP_PAT_LO  = 4;
  localparam int OP_PAT_HI  = 5;
  localparam int OP_MEMOP   = 6;

  // Any pattern with bit 1 set is indexed.
  localparam logic [1:0] PAT_UNIT   = 2'b00;
  localparam logic [1:0] PAT_STRIDE = 2'b01;
  localparam logic [1:0] PAT_INDEX  = 2'b10;

endpackage

// File: rtl/vmem_seq_tailmask.sv
// rtl/vmem_seq_tailmask.sv - vector-length tail mask for one beat
//
// Purpose: lane i of beat k is enabled when element k*NUMLANES+i is below vl.
// Ports:
//   vl    in   VLWIDTH   instruction vector length
//   beat  in   BEATW     beat index
//   en    out  NUMLANES  per-lane enable
module vmem_seq_tailmask #(
  parameter int NUMLANES = 8,
  parameter int VLWIDTH  = 7,
  parameter int BEATW    = 3
) (
  input  logic [VLWIDTH-1:0]  vl,
  input  logic [BEATW-1:0]    beat,
  output logic [NUMLANES-1:0] en
);

  logic [31:0] first_elem;

  always_comb begin
    first_elem = 32'(beat) * 32'(NUMLANES);
    for (int i = 0; i < NUMLANES; i++) begin
      en[i] = (first_elem + 32'(i)) < 32'(vl);
    end
  end

endmodule

// File: rtl/vmem_local_seq.sv
// rtl/vmem_local_seq.sv - vector memory request sequencer driving local memory port A
//
// Purpose: accepts one vector load/store, issues it as NUMLANES-wide beats and
// returns load beats one cycle after issue with their beat tag.
// Optional feature: define VMEM_SEQ_MASK_EN to add the vmask port, ANDed into
// mem_en (and therefore ld_en).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        instruction handshake (ready only in IDLE)
//   req_op/base/stride/vl      instruction fields, latched on acceptance
//   stall                      port A busy, freezes beat issue
//   mem_op/address/stride/offset/en/data  port A request (combinational)
//   mem_out                    port A read data, one cycle after a read issue
//   beat                       registered beat index for register-file reads
//   offset_in, st_data         per-beat indexed offsets and store data
//   vmask                      per-lane mask (VMEM_SEQ_MASK_EN only)
//   ld_valid/ld_beat/ld_data/ld_en  load return to writeback
//   busy, done                 activity flag and single-cycle completion pulse
module vmem_local_seq
  import vmem_seq_pkg::*;
#(
  parameter int NUMLANES     = 8,
  parameter int DATAWORDSIZE = 32,
  parameter int VCWIDTH      = 32,
  parameter int MEMDEPTH     = 2048,
  parameter int LOGMEMDEPTH  = $clog2(MEMDEPTH),
  parameter int MAXVL        = 64,
  parameter int VLWIDTH      = $clog2(MAXVL + 1),
  parameter int BEATW        = $clog2(MAXVL / NUMLANES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [OP_W-1:0]                  req_op,
  input  logic [LOGMEMDEPTH-1:0]           req_base,
  input  logic [VCWIDTH-1:0]               req_stride,
  input  logic [VLWIDTH-1:0]               req_vl,
  input  logic                             stall,
  output logic [OP_W-1:0]                  mem_op,
  output logic [LOGMEMDEPTH-1:0]           mem_address,
  output logic [VCWIDTH-1:0]               mem_stride,
  output logic [NUMLANES*8-1:0]            mem_offset,
  output logic [NUMLANES-1:0]              mem_en,
  output logic [NUMLANES*DATAWORDSIZE-1:0] mem_data,
  input  logic [NUMLANES*DATAWORDSIZE-1:0] mem_out,
  output logic [BEATW-1:0]                 beat,
  input  logic [NUMLANES*8-1:0]            offset_in,
  input  logic [NUMLANES*DATAWORDSIZE-1:0] st_data,
`ifdef VMEM_SEQ_MASK_EN
  input  logic [NUMLANES-1:0]              vmask,
`endif
  output logic                             ld_valid,
  output logic [BEATW-1:0]                 ld_beat,
  output logic [NUMLANES*DATAWORDSIZE-1:0] ld_data,
  output logic [NUMLANES-1:0]              ld_en,
  output logic                             busy,
  output logic                             done
);

  localparam int LOG_NL = $clog2(NUMLANES);

  seq_state_e               state_q, state_d;
  logic [BEATW-1:0]         beat_q, beat_d;
  logic [BEATW-1:0]         last_q, last_d;
  logic [OP_W-1:0]          op_q, op_d;
  logic [LOGMEMDEPTH-1:0]   base_q, base_d;
  logic [VCWIDTH-1:0]       stride_q, stride_d;
  logic [VLWIDTH-1:0]       vl_q, vl_d;
  logic                     zdone_q, zdone_d;
  logic                     ld_valid_q, ld_valid_d;
  logic [BEATW-1:0]         ld_beat_q, ld_beat_d;
  logic [NUMLANES-1:0]      ld_en_q, ld_en_d;

  logic                     issue;
  logic                     last_issue;
  logic                     in_issue;
  logic [31:0]              nbeats;
  logic [NUMLANES-1:0]      tail_en;
  logic [NUMLANES-1:0]      lane_en;
  logic [1:0]               pat;
  logic [VCWIDTH-1:0]       beat_ext;
  logic [VCWIDTH-1:0]       unit_off;
  logic [VCWIDTH-1:0]       stride_off;
  logic [LOGMEMDEPTH-1:0]   addr_calc;

  vmem_seq_tailmask #(
    .NUMLANES (NUMLANES),
    .VLWIDTH  (VLWIDTH),
    .BEATW    (BEATW)
  ) u_tailmask (
    .vl   (vl_q),
    .beat (beat_q),
    .en   (tail_en)
  );

`ifdef VMEM_SEQ_MASK_EN
  assign lane_en = tail_en & vmask;
`else
  assign lane_en = tail_en;
`endif

  // Offsets are formed at VCWIDTH and truncated, which gives the silent
  // modulo-MEMDEPTH wrap for both unit and strided patterns.
  always_comb begin
    pat        = op_q[OP_PAT_HI:OP_PAT_LO];
    beat_ext   = VCWIDTH'(beat_q);
    unit_off   = beat_ext << LOG_NL;
    stride_off = (beat_ext * stride_q) << LOG_NL;
    if (pat == PAT_UNIT) begin
      addr_calc = base_q + unit_off[LOGMEMDEPTH-1:0];
    end else if (pat == PAT_STRIDE) begin
      addr_calc = base_q + stride_off[LOGMEMDEPTH-1:0];
    end else begin
      addr_calc = base_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_d     = last_q;
    op_d       = op_q;
    base_d     = base_q;
    stride_d   = stride_q;
    vl_d       = vl_q;
    zdone_d    = 1'b0;
    ld_valid_d = 1'b0;
    ld_beat_d  = '0;
    ld_en_d    = '0;
    issue      = 1'b0;
    last_issue = 1'b0;
    nbeats     = (32'(req_vl) + 32'(NUMLANES - 1)) >> LOG_NL;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          base_d   = req_base;
          stride_d = req_stride;
          vl_d     = req_vl;
          beat_d   = '0;
          last_d   = BEATW'(nbeats - 32'd1);
          // An empty instruction never leaves IDLE; it only reports completion.
          if (req_vl == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        issue = !stall;
        if (issue) begin
          if (!op_q[OP_WE]) begin
            ld_valid_d = 1'b1;
            ld_beat_d  = beat_q;
            ld_en_d    = lane_en;
          end
          if (beat_q == last_q) begin
            last_issue = 1'b1;
            beat_d     = '0;
            state_d    = op_q[OP_WE] ? ST_IDLE : ST_DRAIN;
          end else begin
            beat_d = beat_q + BEATW'(1);
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      last_q     <= '0;
      op_q       <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      vl_q       <= '0;
      zdone_q    <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_beat_q  <= '0;
      ld_en_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      op_q       <= op_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      vl_q       <= vl_d;
      zdone_q    <= zdone_d;
      ld_valid_q <= ld_valid_d;
      ld_beat_q  <= ld_beat_d;
      ld_en_q    <= ld_en_d;
    end
  end

  // Port A fields are held during a stall; only mem_op drops.
  assign in_issue    = (state_q == ST_ISSUE);
  assign req_ready   = (state_q == ST_IDLE);
  assign mem_op      = issue ? op_q : '0;
  assign mem_address = in_issue ? addr_calc : '0;
  assign mem_stride  = in_issue ? stride_q : '0;
  assign mem_offset  = in_issue ? offset_in : '0;
  assign mem_en      = in_issue ? lane_en : '0;
  assign mem_data    = in_issue ? st_data : '0;
  assign beat        = beat_q;
  assign ld_valid    = ld_valid_q;
  assign ld_beat     = ld_beat_q;
  assign ld_en       = ld_en_q;
  // The RAM presents read data in the cycle after issue, aligned with ld_valid.
  assign ld_data     = ld_valid_q ? mem_out : '0;
  assign busy        = (state_q != ST_IDLE);
  // Store completion coincides with the last issue; load completion with the drain cycle.
  assign done        = zdone_q | (last_issue & op_q[OP_WE]) | (state_q == ST_DRAIN);

endmodule

// File: tb/tb_vmem_local_seq.sv
// tb/tb_vmem_local_seq.sv - directed and randomized bench for vmem_local_seq
module tb_vmem_local_seq;

  localparam int NL  = 8;
  localparam int DW  = 32;
  localparam int VCW = 32;
  localparam int LMD = 11;
  localparam int VLW = 7;
  localparam int BW  = 3;
  localparam int TC  = 30;

`ifdef VMEM_SEQ_MASK_EN
  localparam bit HAS_MASK = 1'b1;
`else
  localparam bit HAS_MASK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [6:0]        req_op;
  logic [LMD-1:0]    req_base;
  logic [VCW-1:0]    req_stride;
  logic [VLW-1:0]    req_vl;
  logic              stall;
  logic [6:0]        mem_op;
  logic [LMD-1:0]    mem_address;
  logic [VCW-1:0]    mem_stride;
  logic [NL*8-1:0]   mem_offset;
  logic [NL-1:0]     mem_en;
  logic [NL*DW-1:0]  mem_data;
  logic [NL*DW-1:0]  mem_out = '0;
  logic [BW-1:0]     beat;
  logic [NL*8-1:0]   offset_in;
  logic [NL*DW-1:0]  st_data;
  logic [NL-1:0]     vmask;
  logic              ld_valid;
  logic [BW-1:0]     ld_beat;
  logic [NL*DW-1:0]  ld_data;
  logic [NL-1:0]     ld_en;
  logic              busy;
  logic              done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vmem_local_seq dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_base    (req_base),
    .req_stride  (req_stride),
    .req_vl      (req_vl),
    .stall       (stall),
    .mem_op      (mem_op),
    .mem_address (mem_address),
    .mem_stride  (mem_stride),
    .mem_offset  (mem_offset),
    .mem_en      (mem_en),
    .mem_data    (mem_data),
    .mem_out     (mem_out),
    .beat        (beat),
    .offset_in   (offset_in),
    .st_data     (st_data),
`ifdef VMEM_SEQ_MASK_EN
    .vmask       (vmask),
`endif
    .ld_valid    (ld_valid),
    .ld_beat     (ld_beat),
    .ld_data     (ld_data),
    .ld_en       (ld_en),
    .busy        (busy),
    .done        (done)
  );

  // Content of the local RAM: each lane word encodes its address and lane.
  function automatic logic [NL*DW-1:0] ram_line(input logic [LMD-1:0] a);
    logic [NL*DW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = {5'd0, a, 8'h00, 8'(i)} ^ 32'h5A00_00C3;
    return r;
  endfunction

  // Synchronous-read RAM on port A.
  always @(posedge clk) begin
    if (mem_op != 7'd0 && !mem_op[0]) mem_out <= ram_line(mem_address);
  end

  // Observed trace, indexed by cycle after acceptance.
  logic [6:0]       t_op   [0:TC+1];
  logic [LMD-1:0]   t_addr [0:TC+1];
  logic [NL-1:0]    t_en   [0:TC+1];
  logic [BW-1:0]    t_beat [0:TC+1];
  logic             t_ldv  [0:TC+1];
  logic [BW-1:0]    t_ldb  [0:TC+1];
  logic [NL*DW-1:0] t_ldd  [0:TC+1];
  logic [NL-1:0]    t_lde  [0:TC+1];
  logic             t_done [0:TC+1];
  logic [NL*DW-1:0] t_md   [0:TC+1];
  logic [NL*DW-1:0] t_sd   [0:TC+1];
  logic [NL*8-1:0]  t_mo   [0:TC+1];
  logic [NL*8-1:0]  t_oi   [0:TC+1];

  // Expected trace from the model.
  logic [6:0]       e_op   [0:TC+1];
  logic             e_act  [0:TC+1];
  logic [LMD-1:0]   e_addr [0:TC+1];
  logic [NL-1:0]    e_en   [0:TC+1];
  logic [BW-1:0]    e_beat [0:TC+1];
  logic             e_ldv  [0:TC+1];
  logic [BW-1:0]    e_ldb  [0:TC+1];
  logic [NL*DW-1:0] e_ldd  [0:TC+1];
  logic [NL-1:0]    e_lde  [0:TC+1];
  logic             e_done [0:TC+1];

  task automatic run_instr(input logic [6:0] op, input logic [LMD-1:0] base,
                           input logic [VCW-1:0] stride, input logic [VLW-1:0] vl,
                           input logic [TC:0] stalls, input logic [NL-1:0] mask);
    req_op = op; req_base = base; req_stride = stride; req_vl = vl;
    req_valid = 1'b1; stall = 1'b0; vmask = mask;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 7'($urandom); req_base = LMD'($urandom); req_stride = $urandom; req_vl = VLW'($urandom);
    for (int c = 1; c <= TC; c++) begin
      stall = stalls[c];
      for (int i = 0; i < NL; i++) st_data[i*DW +: DW] = $urandom;
      offset_in = {$urandom, $urandom};
      @(negedge clk);
      t_op[c] = mem_op; t_addr[c] = mem_address; t_en[c] = mem_en; t_beat[c] = beat;
      t_ldv[c] = ld_valid; t_ldb[c] = ld_beat; t_ldd[c] = ld_data; t_lde[c] = ld_en;
      t_done[c] = done; t_md[c] = mem_data; t_sd[c] = st_data; t_mo[c] = mem_offset; t_oi[c] = offset_in;
      @(posedge clk); #1;
    end
    stall = 1'b0;
  endtask

  // Schedule model: walk cycles, skip stalled ones, issue beats in order.
  task automatic model_instr(input logic [6:0] op, input logic [LMD-1:0] base,
                             input logic [VCW-1:0] stride, input logic [VLW-1:0] vl,
                             input logic [TC:0] stalls, input logic [NL-1:0] mask);
    int n, k;
    longint unsigned lb, lk, ls, a;
    for (int c = 0; c <= TC + 1; c++) begin
      e_op[c] = '0; e_act[c] = 0; e_addr[c] = '0; e_en[c] = '0; e_beat[c] = '0;
      e_ldv[c] = 0; e_ldb[c] = '0; e_ldd[c] = '0; e_lde[c] = '0; e_done[c] = 0;
    end
    n = (int'(vl) + NL - 1) / NL;
    if (n == 0) begin
      e_done[1] = 1'b1;
      return;
    end
    k = 0;
    for (int c = 1; c <= TC && k < n; c++) begin
      lb = longint'(base); lk = longint'(k); ls = longint'(stride);
      case (op[5:4])
        2'b00:   a = (lb + lk * NL) % 2048;
        2'b01:   a = (lb + lk * NL * ls) % 2048;
        default: a = lb;
      endcase
      e_act[c]  = 1'b1;
      e_addr[c] = LMD'(a);
      e_beat[c] = BW'(k);
      for (int i = 0; i < NL; i++) e_en[c][i] = (k * NL + i < int'(vl)) && mask[i];
      if (!stalls[c]) begin
        e_op[c] = op;
        if (!op[0]) begin
          e_ldv[c+1] = 1'b1; e_ldb[c+1] = BW'(k); e_lde[c+1] = e_en[c];
          e_ldd[c+1] = ram_line(e_addr[c]);
        end
        if (k == n - 1) e_done[op[0] ? c : c + 1] = 1'b1;
        k++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_base = '0; req_stride = '0; req_vl = '0;
    stall = 1'b0; offset_in = '0; st_data = '0; vmask = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (mem_op !== 7'd0) begin n_err++; $display("FAIL reset_mem_op got=%h exp=0", mem_op); end
    n_vec++; if (mem_address !== '0 || mem_en !== '0 || mem_stride !== '0) begin
      n_err++; $display("FAIL reset_mem_fields got=%h/%h/%h exp=0", mem_address, mem_en, mem_stride); end
    n_vec++; if (beat !== '0) begin n_err++; $display("FAIL reset_beat got=%0d exp=0", beat); end
    n_vec++; if (ld_valid !== 1'b0 || ld_en !== '0 || ld_beat !== '0 || ld_data !== '0) begin
      n_err++; $display("FAIL reset_ld got=%b/%h/%0d exp=0", ld_valid, ld_en, ld_beat); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_unit_load();
    logic [LMD-1:0] ea [3];
    logic [NL-1:0]  ee [3];
    int nd;
    ea = '{11'd40, 11'd48, 11'd56};
    ee = '{8'hFF, 8'hFF, 8'h0F};
    run_instr(7'h48, 11'd40, 32'd0, 7'd20, '0, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (t_op[k+1] !== 7'h48) begin n_err++; $display("FAIL ul_op k=%0d got=%h exp=48", k, t_op[k+1]); end
      n_vec++; if (t_addr[k+1] !== ea[k]) begin n_err++; $display("FAIL ul_addr k=%0d got=%0d exp=%0d", k, t_addr[k+1], ea[k]); end
      n_vec++; if (t_en[k+1] !== ee[k]) begin n_err++; $display("FAIL ul_en k=%0d got=%h exp=%h", k, t_en[k+1], ee[k]); end
      n_vec++; if (t_ldv[k+2] !== 1'b1 || t_ldb[k+2] !== BW'(k)) begin
        n_err++; $display("FAIL ul_ldbeat k=%0d got=%b/%0d exp=1/%0d", k, t_ldv[k+2], t_ldb[k+2], k); end
      n_vec++; if (t_lde[k+2] !== ee[k]) begin n_err++; $display("FAIL ul_lden k=%0d got=%h exp=%h", k, t_lde[k+2], ee[k]); end
      n_vec++; if (t_ldd[k+2] !== ram_line(ea[k])) begin n_err++; $display("FAIL ul_lddata k=%0d got=%h exp=%h", k, t_ldd[k+2], ram_line(ea[k])); end
    end
    nd = 0;
    for (int c = 1; c <= TC; c++) if (t_done[c]) nd++;
    n_vec++; if (t_done[4] !== 1'b1 || nd != 1) begin n_err++; $display("FAIL ul_done got=%b count=%0d exp=1 count=1", t_done[4], nd); end
    n_vec++; if (t_ldv[5] !== 1'b0) begin n_err++; $display("FAIL ul_extra_ld got=%b exp=0", t_ldv[5]); end
  endtask

  task automatic test_strided_store();
    int nd, nl;
    run_instr(7'h59, 11'd100, 32'd3, 7'd16, '0, 8'hFF);
    n_vec++; if (t_op[1] !== 7'h59 || t_addr[1] !== 11'd100) begin n_err++; $display("FAIL ss_beat0 got=%h/%0d exp=59/100", t_op[1], t_addr[1]); end
    n_vec++; if (t_op[2] !== 7'h59 || t_addr[2] !== 11'd124) begin n_err++; $display("FAIL ss_beat1 got=%h/%0d exp=59/124", t_op[2], t_addr[2]); end
    n_vec++; if (t_en[1] !== 8'hFF || t_en[2] !== 8'hFF) begin n_err++; $display("FAIL ss_en got=%h/%h exp=ff/ff", t_en[1], t_en[2]); end
    n_vec++; if (t_md[1] !== t_sd[1] || t_md[2] !== t_sd[2]) begin n_err++; $display("FAIL ss_data got=%h exp=%h", t_md[1], t_sd[1]); end
    n_vec++; if (t_mo[2] !== t_oi[2]) begin n_err++; $display("FAIL ss_offset got=%h exp=%h", t_mo[2], t_oi[2]); end
    n_vec++; if (t_op[3] !== 7'd0) begin n_err++; $display("FAIL ss_extra_op got=%h exp=0", t_op[3]); end
    nd = 0; nl = 0;
    for (int c = 1; c <= TC; c++) begin
      if (t_done[c]) nd++;
      if (t_ldv[c]) nl++;
    end
    n_vec++; if (t_done[2] !== 1'b1 || nd != 1) begin n_err++; $display("FAIL ss_done got=%b count=%0d exp=1 count=1", t_done[2], nd); end
    n_vec++; if (nl != 0) begin n_err++; $display("FAIL ss_no_load got=%0d exp=0", nl); end
  endtask

  task automatic test_wrap();
    run_instr(7'h48, 11'd2044, 32'd0, 7'd16, '0, 8'hFF);
    n_vec++; if (t_addr[1] !== 11'd2044) begin n_err++; $display("FAIL wrap_a0 got=%0d exp=2044", t_addr[1]); end
    n_vec++; if (t_addr[2] !== 11'd4) begin n_err++; $display("FAIL wrap_a1 got=%0d exp=4", t_addr[2]); end
    n_vec++; if (t_ldd[3] !== ram_line(11'd4)) begin n_err++; $display("FAIL wrap_lddata got=%h exp=%h", t_ldd[3], ram_line(11'd4)); end
    n_vec++; if (t_done[3] !== 1'b1) begin n_err++; $display("FAIL wrap_done got=%b exp=1", t_done[3]); end
  endtask

  task automatic test_stall();
    logic [TC:0] s;
    int ic [4];
    int nd;
    s = '0; s[2] = 1'b1; s[3] = 1'b1;
    ic = '{1, 4, 5, 6};
    run_instr(7'h48, 11'd0, 32'd0, 7'd32, s, 8'hFF);
    n_vec++; if (t_op[2] !== 7'd0 || t_op[3] !== 7'd0) begin n_err++; $display("FAIL st_op got=%h/%h exp=0/0", t_op[2], t_op[3]); end
    n_vec++; if (t_beat[2] !== 3'd1 || t_beat[3] !== 3'd1) begin n_err++; $display("FAIL st_beat_hold got=%0d/%0d exp=1/1", t_beat[2], t_beat[3]); end
    n_vec++; if (t_addr[3] !== 11'd8) begin n_err++; $display("FAIL st_addr_hold got=%0d exp=8", t_addr[3]); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (t_op[ic[k]] !== 7'h48 || t_addr[ic[k]] !== 11'(8 * k)) begin
        n_err++; $display("FAIL st_issue k=%0d got=%h/%0d exp=48/%0d", k, t_op[ic[k]], t_addr[ic[k]], 8 * k); end
      n_vec++; if (t_ldv[ic[k]+1] !== 1'b1 || t_ldb[ic[k]+1] !== BW'(k)) begin
        n_err++; $display("FAIL st_ldbeat k=%0d got=%b/%0d exp=1/%0d", k, t_ldv[ic[k]+1], t_ldb[ic[k]+1], k); end
    end
    nd = 0;
    for (int c = 1; c <= TC; c++) if (t_done[c]) nd++;
    n_vec++; if (t_done[7] !== 1'b1 || nd != 1) begin n_err++; $display("FAIL st_done got=%b count=%0d exp=1 count=1", t_done[7], nd); end
  endtask

  task automatic test_zero_vl();
    int nd, no;
    run_instr(7'h59, 11'd5, 32'd0, 7'd0, '0, 8'hFF);
    nd = 0; no = 0;
    for (int c = 1; c <= TC; c++) begin
      if (t_done[c]) nd++;
      if (t_op[c] != 7'd0) no++;
    end
    n_vec++; if (t_done[1] !== 1'b1 || nd != 1) begin n_err++; $display("FAIL zv_done got=%b count=%0d exp=1 count=1", t_done[1], nd); end
    n_vec++; if (no != 0) begin n_err++; $display("FAIL zv_mem_op got=%0d exp=0", no); end
  endtask

  task automatic test_reset_mid_load();
    int seen;
    req_op = 7'h48; req_base = 11'd200; req_stride = '0; req_vl = 7'd32; req_valid = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (beat !== 3'd1 || mem_op !== 7'h48) begin n_err++; $display("FAIL rm_pre got=%0d/%h exp=1/48", beat, mem_op); end
    reset = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b1 || busy !== 1'b0 || beat !== '0) begin
      n_err++; $display("FAIL rm_state got=%b/%b/%0d exp=1/0/0", req_ready, busy, beat); end
    n_vec++; if (mem_op !== '0 || mem_en !== '0 || mem_address !== '0 || ld_valid !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rm_outputs got=%h/%h/%0d/%b/%b exp=0", mem_op, mem_en, mem_address, ld_valid, done); end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ld_valid || done || mem_op != 7'd0) seen++;
      @(posedge clk); #1;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL rm_after got=%0d exp=0", seen); end
  endtask

  task automatic test_mask();
    run_instr(7'h59, 11'd0, 32'd0, 7'd8, '0, 8'hAA);
    n_vec++; if (t_en[1] !== (HAS_MASK ? 8'hAA : 8'hFF)) begin n_err++; $display("FAIL mask_en got=%h exp=%h", t_en[1], HAS_MASK ? 8'hAA : 8'hFF); end
    n_vec++; if (t_done[1] !== 1'b1) begin n_err++; $display("FAIL mask_done got=%b exp=1", t_done[1]); end
  endtask

  task automatic test_random();
    logic [6:0]     op;
    logic [LMD-1:0] base;
    logic [VCW-1:0] stride;
    logic [VLW-1:0] vl;
    logic [TC:0]    s;
    logic [NL-1:0]  mask;
    for (int it = 0; it < 25; it++) begin
      op     = {1'b1, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom)};
      base   = LMD'($urandom);
      stride = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      vl     = VLW'($urandom_range(0, 64));
      mask   = HAS_MASK ? 8'($urandom) : 8'hFF;
      s      = '0;
      for (int c = 1; c <= 12; c++) s[c] = ($urandom_range(0, 3) == 0);
      model_instr(op, base, stride, vl, s, mask);
      run_instr(op, base, stride, vl, s, mask);
      for (int c = 1; c <= TC; c++) begin
        n_vec++; if (t_op[c] !== e_op[c]) begin n_err++; $display("FAIL rnd_op it=%0d c=%0d got=%h exp=%h", it, c, t_op[c], e_op[c]); end
        if (e_act[c]) begin
          n_vec++; if (t_addr[c] !== e_addr[c]) begin n_err++; $display("FAIL rnd_addr it=%0d c=%0d got=%0d exp=%0d", it, c, t_addr[c], e_addr[c]); end
          n_vec++; if (t_en[c] !== e_en[c]) begin n_err++; $display("FAIL rnd_en it=%0d c=%0d got=%h exp=%h", it, c, t_en[c], e_en[c]); end
          n_vec++; if (t_beat[c] !== e_beat[c]) begin n_err++; $display("FAIL rnd_beat it=%0d c=%0d got=%0d exp=%0d", it, c, t_beat[c], e_beat[c]); end
        end
        n_vec++; if (t_ldv[c] !== e_ldv[c]) begin n_err++; $display("FAIL rnd_ldv it=%0d c=%0d got=%b exp=%b", it, c, t_ldv[c], e_ldv[c]); end
        if (e_ldv[c]) begin
          n_vec++; if (t_ldb[c] !== e_ldb[c] || t_lde[c] !== e_lde[c]) begin
            n_err++; $display("FAIL rnd_ldtag it=%0d c=%0d got=%0d/%h exp=%0d/%h", it, c, t_ldb[c], t_lde[c], e_ldb[c], e_lde[c]); end
          n_vec++; if (t_ldd[c] !== e_ldd[c]) begin n_err++; $display("FAIL rnd_lddata it=%0d c=%0d got=%h exp=%h", it, c, t_ldd[c], e_ldd[c]); end
        end
        n_vec++; if (t_done[c] !== e_done[c]) begin n_err++; $display("FAIL rnd_done it=%0d c=%0d got=%b exp=%b", it, c, t_done[c], e_done[c]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unit_load();
    test_strided_store();
    test_wrap();
    test_stall();
    test_zero_vl();
    test_reset_mid_load();
    test_mask();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vmem_local_seq.md
# vmem_local_seq

Vector memory request sequencer. It sits directly upstream of the per-lane local vector memory and drives that memory's port A. It accepts one vector load/store instruction (op, base, stride, vector length) and splits it into NUMLANES-wide beats. For each beat it drives address, op, stride, offsets, lane enables and store data. One cycle later it returns load data to the vector register file writeback with beat tags.

## Interface
Parameters:
- NUMLANES, 8, lanes per beat; must be a power of two.
- DATAWORDSIZE, 32, bits per lane element.
- VCWIDTH, 32, stride width.
- MEMDEPTH, 2048, words per lane RAM.
- LOGMEMDEPTH, $clog2(MEMDEPTH), address width.
- MAXVL, 64, maximum vector length.
- VLWIDTH, $clog2(MAXVL+1), width of the vector-length field.
- BEATW, $clog2(MAXVL/NUMLANES), width of the beat index.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  instruction offered.
- req_ready  out  1  high only in IDLE.
- req_op  in  7  fields {memop, pattern[1:0], size[1:0], signed, we}.
- req_base  in  LOGMEMDEPTH  base address.
- req_stride  in  VCWIDTH  element stride; used only when pattern==01.
- req_vl  in  VLWIDTH  element count, 0..MAXVL.
- stall  in  1  port A busy; freezes beat issue.
- mem_op  out  7  op to memory; 0 when not issuing.
- mem_address  out  LOGMEMDEPTH  beat base address.
- mem_stride  out  VCWIDTH  stride passed through.
- mem_offset  out  NUMLANES*8  passthrough of offset_in.
- mem_en  out  NUMLANES  lane write enables.
- mem_data  out  NUMLANES*DATAWORDSIZE  passthrough of st_data.
- mem_out  in  NUMLANES*DATAWORDSIZE  read data, valid 1 cycle after the read is issued.
- beat  out  BEATW  current beat index (feeds register-file read for offsets and store data).
- offset_in  in  NUMLANES*8  indexed offsets for `beat`; same-cycle.
- st_data  in  NUMLANES*DATAWORDSIZE  store data for `beat`; same-cycle.
- vmask  in  NUMLANES  per-lane mask for `beat` (present only with VMEM_SEQ_MASK_EN).
- ld_valid  out  1  load beat returned.
- ld_beat  out  BEATW  beat tag for the returned load.
- ld_data  out  NUMLANES*DATAWORDSIZE  the registered-capture of mem_out.
- ld_en  out  NUMLANES  lanes valid in ld_data.
- busy  out  1  state != IDLE.
- done  out  1  single-cycle completion pulse.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE with req_valid: latch the request. Set beat=0 and nbeats=ceil(vl/NUMLANES).
  - vl==0: stay in IDLE and pulse done next cycle.
  - vl>0: go to ISSUE.
- ISSUE: `issue = !stall`.
  - When issue, mem_op=latched op; otherwise mem_op=0.
  - Per beat k:
    - unit stride (pattern 00): mem_address = base + k*NUMLANES.
    - strided (01): mem_address = base + k*NUMLANES*stride.
    - indexed (1x): mem_address = base.
  - Address arithmetic is modulo 2^LOGMEMDEPTH (wraps silently). The stride product is truncated to LOGMEMDEPTH bits.
  - mem_en[i] = (k*NUMLANES+i < vl), ANDed with vmask[i] when the macro is enabled.
  - On issue of the last beat:
    - store: go to IDLE and pulse done in the same cycle.
    - load: go to DRAIN.
  - On issue of any other beat, beat increments.
- DRAIN: lasts one cycle for the final load return. Pulse done together with the last ld_valid, then go to IDLE.
- Load return: for every issued load beat, one cycle later: ld_valid=1, ld_beat=k, ld_data=mem_out, ld_en=mem_en of beat k. There is no backpressure on load return.
- Stall: beat, address and en hold. Nothing is issued. Loads already issued still return.
- reset asserted at any time: go to IDLE and discard all pending work. No ld_valid or done follows the reset.

## Timing
- Reset values: req_ready=1 (combinational from IDLE); every other output is 0, and beat=0.
- Issue rate: one beat per unstalled cycle.
- Load latency: 1 cycle from issue to ld_valid.
- Completion of an unstalled instruction:
  - load of n beats: done at cycle n+1 after acceptance.
  - store of n beats: done at cycle n.
- mem_* outputs are combinational from registered state plus stall. beat is registered.

## Configuration
- VMEM_SEQ_MASK_EN defined: the vmask port exists and is ANDed into mem_en and ld_en.
- Not defined: the port is absent and enables come from the vl tail mask only.

## Structure
- Shared package vmem_seq_pkg holds:
  - the FSM state enum;
  - op field bit positions;
  - pattern codes (UNIT=00, STRIDE=01, INDEX=1x).
- One sub-module, vmem_seq_tailmask: combinational (vl, beat) → NUMLANES enable vector.

## Test plan
- Unit load, vl=20, base=40 → addresses 40,48,56; mem_en 0xFF,0xFF,0x0F; ld_valid on 3 consecutive cycles with ld_beat 0,1,2; done with beat 2.
- Strided store, stride=3, base=100, vl=16 → addresses 100,124; done on the second issue cycle; ld_valid never asserts.
- Wrap-around: base=2044, unit load, vl=16 → addresses 2044, then 4 (mod 2048).
- Stall asserted 2 cycles mid-load → mem_op=0 and beat held during the stall; ld_beat sequence unchanged; done delayed by 2 cycles.
- vl=0 store → no mem_op, done pulse 1 cycle after acceptance; reset asserted during beat 1 of a load → IDLE, all outputs 0, no further ld_valid.
- With VMEM_SEQ_MASK_EN, vmask=0xAA, vl=8 store → mem_en=0xAA.
